// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-port data memory between requester A
// (CPU data side) and requester B (loader/debug side). At most one access is
// issued per cycle; the winner's access completes in its grant cycle and a
// registered completion (rvalid + rdata) follows one cycle later.
//
// Build option:
//   DATA_ARB_ROUND_ROBIN_EN  - defined: simultaneous requests alternate,
//                              starting with B after reset.
//                              undefined: fixed priority, A always wins a tie.
// Address width defaults to `DATA_BITS-2 (word addressing of a byte space).

`ifndef DATA_BITS
`define DATA_BITS 12
`endif

module data_memory_arbiter #(
  parameter int ADDR_W = `DATA_BITS - 2
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_wren,
  input  logic [3:0]        a_byteena,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,

  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_wren,
  input  logic [3:0]        b_byteena,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

`ifdef DATA_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  // 1 = B won the most recent arbitration; only changes on a grant.
  logic last_b;
  logic grant_a;
  logic grant_b;
  logic tie_pick_b;

  // On a tie, round-robin hands the slot to whoever did not win last time;
  // fixed priority always leaves a tie with A.
  assign tie_pick_b = ROUND_ROBIN && !last_b;

  // Pick at most one requester; reset suppresses every grant immediately.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_req && b_req) begin
        grant_a = !tie_pick_b;
        grant_b = tie_pick_b;
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  // Steer the winner onto the memory port; an idle port drives all zeros.
  always_comb begin
    mem_address = '0;
    mem_byteena = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (grant_a) begin
      mem_address = a_addr;
      mem_byteena = a_byteena;
      mem_data    = a_wdata;
      mem_wren    = a_wren;
    end else if (grant_b) begin
      mem_address = b_addr;
      mem_byteena = b_byteena;
      mem_data    = b_wdata;
      mem_wren    = b_wren;
    end
  end

  // Completion for side A: strobe for one cycle, capture the word read during the grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
    end else begin
      a_rvalid <= grant_a;
      if (grant_a) begin
        a_rdata <= mem_q;
      end
    end
  end

  // Completion for side B: same behaviour as side A.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      b_rvalid <= grant_b;
      if (grant_b) begin
        b_rdata <= mem_q;
      end
    end
  end

  // Remember which side won the latest arbitration; idle cycles leave it alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_b <= 1'b0;
    end else if (grant_a || grant_b) begin
      last_b <= grant_b;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: bench for data_memory_arbiter with a behavioural
// byte-enabled memory. Expected completions are queued per side when a
// request is driven and matched against rvalid/rdata by a monitor.
// Arbitration expectations follow DATA_ARB_ROUND_ROBIN_EN when defined.

module tb_data_memory_arbiter;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              a_req, b_req;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_wren, b_wren;
  logic [3:0]        a_byteena, b_byteena;
  logic [31:0]       a_wdata, b_wdata;
  logic              a_gnt, b_gnt;
  logic              a_rvalid, b_rvalid;
  logic [31:0]       a_rdata, b_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteena;
  logic [31:0]       mem_data;
  logic              mem_wren;
  logic [31:0]       mem_q;

  logic [31:0]       memArray [0:DEPTH-1];
  logic [31:0]       refMem   [0:DEPTH-1];
  logic              preloadEn;
  logic [ADDR_W-1:0] preloadAddr;
  logic [31:0]       preloadData;

  logic [31:0]       aQ[$];
  logic [31:0]       bQ[$];
  int                checks;
  int                fails;

  data_memory_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wren(a_wren), .a_byteena(a_byteena),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wren(b_wren), .b_byteena(b_byteena),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: combinational read, synchronous byte-enabled write, bench preload port.
  assign mem_q = memArray[mem_address];
  always @(posedge clock) begin
    if (preloadEn) begin
      memArray[preloadAddr] <= preloadData;
    end else if (mem_wren) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_byteena[k]) memArray[mem_address][8*k +: 8] <= mem_data[8*k +: 8];
      end
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every completion must match the oldest queued expectation.
  task automatic monitor();
    logic [31:0] expData;
    forever begin
      @(negedge clock);
      if (a_rvalid) begin
        checks++;
        if (aQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL a_unexpected_rvalid: got rvalid with rdata=%h, required no completion", a_rdata);
        end else begin
          expData = aQ.pop_front();
          if (a_rdata !== expData) begin
            fails++;
            $display("[TB] FAIL a_rdata_scoreboard: got %h, required %h", a_rdata, expData);
          end
        end
      end
      if (b_rvalid) begin
        checks++;
        if (bQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL b_unexpected_rvalid: got rvalid with rdata=%h, required no completion", b_rdata);
        end else begin
          expData = bQ.pop_front();
          if (b_rdata !== expData) begin
            fails++;
            $display("[TB] FAIL b_rdata_scoreboard: got %h, required %h", b_rdata, expData);
          end
        end
      end
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    preloadAddr = addr;
    preloadData = data;
    preloadEn   = 1'b1;
    refMem[addr] = data;
    @(posedge clock); #1;
    preloadEn = 1'b0;
  endtask

  task automatic test_reset();
    a_req = 1'b1; a_wren = 1'b1; a_byteena = 4'hF;
    b_req = 1'b1; b_wren = 1'b1; b_byteena = 4'hF;
    #1;
    checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_gnt: got a=%b b=%b, required 0 0", a_gnt, b_gnt);
    end
    checks++;
    if (mem_wren !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_mem_wren: got %b, required 0", mem_wren);
    end
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_rvalid: got a=%b b=%b, required 0 0", a_rvalid, b_rvalid);
    end
    checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_rdata: got a=%h b=%h, required 0 0", a_rdata, b_rdata);
    end
    a_req = 1'b0; a_wren = 1'b0; a_byteena = 4'h0;
    b_req = 1'b0; b_wren = 1'b0; b_byteena = 4'h0;
    @(posedge clock); #1;
  endtask

  task automatic test_arbitration();
    logic expB;
    logic lastB;
    lastB = 1'b0;
    reset = 1'b0;
    a_req = 1'b1; a_addr = ADDR_W'(12'h030); a_wren = 1'b0;
    b_req = 1'b1; b_addr = ADDR_W'(12'h031); b_wren = 1'b0;
    for (int c = 0; c < 6; c++) begin
`ifdef DATA_ARB_ROUND_ROBIN_EN
      expB = !lastB;
`else
      expB = 1'b0;
`endif
      #1;
      checks++;
      if (a_gnt !== !expB || b_gnt !== expB) begin
        fails++;
        $display("[TB] FAIL arb_grant_%0d: got a=%b b=%b, required a=%b b=%b", c, a_gnt, b_gnt, !expB, expB);
      end
      if (c > 0) begin
        checks++;
        if ((a_rvalid ^ b_rvalid) !== 1'b1) begin
          fails++;
          $display("[TB] FAIL arb_one_rvalid_%0d: got a=%b b=%b, required exactly one", c, a_rvalid, b_rvalid);
        end
      end
      if (expB) bQ.push_back(refMem[ADDR_W'(12'h031)]);
      else      aQ.push_back(refMem[ADDR_W'(12'h030)]);
      lastB = expB;
      @(posedge clock); #1;
    end
    a_req = 1'b0;
    #1;
    checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      fails++; $display("[TB] FAIL arb_b_after_a_drops: got a=%b b=%b, required a=0 b=1", a_gnt, b_gnt);
    end
    checks++;
    if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin
      fails++; $display("[TB] FAIL arb_last_a_rvalid: got a=%b b=%b, required a=1 b=0", a_rvalid, b_rvalid);
    end
    bQ.push_back(refMem[ADDR_W'(12'h031)]);
    @(posedge clock); #1;
    b_req = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (aQ.size() != 0 || bQ.size() != 0) begin
      fails++; $display("[TB] FAIL arb_drain: got %0d/%0d pending, required 0/0", aQ.size(), bQ.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single_read();
    a_req = 1'b1; a_addr = ADDR_W'(12'h010); a_wren = 1'b0; a_byteena = 4'h0; a_wdata = 32'h0;
    #1;
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      fails++; $display("[TB] FAIL read_gnt: got a=%b b=%b, required a=1 b=0", a_gnt, b_gnt);
    end
    checks++;
    if (mem_address !== ADDR_W'(12'h010) || mem_wren !== 1'b0) begin
      fails++; $display("[TB] FAIL read_mem_port: got addr=%h wren=%b, required addr=010 wren=0", mem_address, mem_wren);
    end
    aQ.push_back(refMem[ADDR_W'(12'h010)]);
    @(posedge clock); #1;
    a_req = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rvalid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_completion: got a_rvalid=%b a_rdata=%h b_rvalid=%b, required 1 deadbeef 0", a_rvalid, a_rdata, b_rvalid);
    end
    checks++;
    if (mem_address !== '0 || mem_data !== 32'h0 || mem_byteena !== 4'h0 || mem_wren !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_mem_port: got addr=%h data=%h be=%b wren=%b, required all 0", mem_address, mem_data, mem_byteena, mem_wren);
    end
    @(negedge clock); #1;
    checks++;
    if (aQ.size() != 0 || bQ.size() != 0) begin
      fails++; $display("[TB] FAIL read_drain: got %0d/%0d pending, required 0/0", aQ.size(), bQ.size());
    end
    @(posedge clock); #1;
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL read_hold: got rvalid=%b rdata=%h, required 0 deadbeef", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_byte_write();
    logic [ADDR_W-1:0] wa;
    wa = ADDR_W'(12'h020);
    b_req = 1'b1; b_addr = wa; b_wren = 1'b1; b_byteena = 4'b0101; b_wdata = 32'h11223344;
    #1;
    checks++;
    if (b_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_byteena !== 4'b0101 || mem_data !== 32'h11223344) begin
      fails++;
      $display("[TB] FAIL write_mem_port: got gnt=%b wren=%b be=%b data=%h, required 1 1 0101 11223344", b_gnt, mem_wren, mem_byteena, mem_data);
    end
    bQ.push_back(refMem[wa]);
    for (int k = 0; k < 4; k++) begin
      if (b_byteena[k]) refMem[wa][8*k +: 8] = b_wdata[8*k +: 8];
    end
    @(posedge clock); #1;
    b_req = 1'b0; b_wren = 1'b0; b_byteena = 4'h0;
    a_req = 1'b1; a_addr = wa; a_wren = 1'b0;
    #1;
    checks++;
    if (a_gnt !== 1'b1 || b_rvalid !== 1'b1 || b_rdata !== 32'hAAAAAAAA) begin
      fails++;
      $display("[TB] FAIL write_b2b: got a_gnt=%b b_rvalid=%b b_rdata=%h, required 1 1 aaaaaaaa", a_gnt, b_rvalid, b_rdata);
    end
    aQ.push_back(refMem[wa]);
    @(posedge clock); #1;
    a_req = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hAA22AA44) begin
      fails++; $display("[TB] FAIL write_readback: got rvalid=%b rdata=%h, required 1 aa22aa44", a_rvalid, a_rdata);
    end
    @(negedge clock); #1;
    checks++;
    if (aQ.size() != 0 || bQ.size() != 0) begin
      fails++; $display("[TB] FAIL write_drain: got %0d/%0d pending, required 0/0", aQ.size(), bQ.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_alternating();
    logic prevA;
    logic curA;
    prevA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      curA = (i % 2) == 0;
      a_req = curA;  a_addr = ADDR_W'(12'h050 + i); a_wren = 1'b0;
      b_req = !curA; b_addr = ADDR_W'(12'h050 + i); b_wren = 1'b0;
      #1;
      checks++;
      if (a_gnt !== curA || b_gnt !== !curA) begin
        fails++; $display("[TB] FAIL alt_gnt_%0d: got a=%b b=%b, required a=%b b=%b", i, a_gnt, b_gnt, curA, !curA);
      end
      if (i > 0) begin
        checks++;
        if (a_rvalid !== prevA || b_rvalid !== !prevA) begin
          fails++; $display("[TB] FAIL alt_rvalid_%0d: got a=%b b=%b, required a=%b b=%b", i, a_rvalid, b_rvalid, prevA, !prevA);
        end
      end
      if (curA) aQ.push_back(refMem[ADDR_W'(12'h050 + i)]);
      else      bQ.push_back(refMem[ADDR_W'(12'h050 + i)]);
      prevA = curA;
      @(posedge clock); #1;
    end
    a_req = 1'b0; b_req = 1'b0;
    #1;
    checks++;
    if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0) begin
      fails++; $display("[TB] FAIL alt_last_rvalid: got a=%b b=%b, required a=0 b=1", a_rvalid, b_rvalid);
    end
    @(negedge clock); #1;
    checks++;
    if (aQ.size() != 0 || bQ.size() != 0) begin
      fails++; $display("[TB] FAIL alt_drain: got %0d/%0d pending, required 0/0", aQ.size(), bQ.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [ADDR_W-1:0] wa;
    wa = ADDR_W'(12'h040);
    a_req = 1'b1; a_addr = wa; a_wren = 1'b1; a_byteena = 4'hF; a_wdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (a_gnt !== 1'b1 || mem_wren !== 1'b1) begin
      fails++; $display("[TB] FAIL rstw_pre_gnt: got gnt=%b wren=%b, required 1 1", a_gnt, mem_wren);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wren !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      fails++; $display("[TB] FAIL rstw_drop: got wren=%b a_gnt=%b b_gnt=%b, required 0 0 0", mem_wren, a_gnt, b_gnt);
    end
    checks++;
    if (mem_address !== '0 || mem_data !== 32'h0 || mem_byteena !== 4'h0) begin
      fails++; $display("[TB] FAIL rstw_mem_zero: got addr=%h data=%h be=%b, required all 0", mem_address, mem_data, mem_byteena);
    end
    @(posedge clock); #1;
    a_req = 1'b0; a_wren = 1'b0; a_byteena = 4'h0; a_wdata = 32'h0;
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL rstw_outputs: got rv=%b/%b rd=%h/%h, required all 0", a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    checks++;
    if (memArray[wa] !== 32'h55667788) begin
      fails++; $display("[TB] FAIL rstw_mem_word: got %h, required 55667788", memArray[wa]);
    end
    reset = 1'b0;
    a_req = 1'b1; a_addr = wa;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin
      fails++; $display("[TB] FAIL rstw_first_cycle_gnt: got %b, required 1", a_gnt);
    end
    aQ.push_back(refMem[wa]);
    @(posedge clock); #1;
    a_req = 1'b0;
    #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h55667788) begin
      fails++; $display("[TB] FAIL rstw_readback: got rvalid=%b rdata=%h, required 1 55667788", a_rvalid, a_rdata);
    end
    @(negedge clock); #1;
    checks++;
    if (aQ.size() != 0 || bQ.size() != 0) begin
      fails++; $display("[TB] FAIL rstw_drain: got %0d/%0d pending, required 0/0", aQ.size(), bQ.size());
    end
    @(posedge clock); #1;
  endtask

  // Main sequence: reset checks, preloads while still in reset, then scenarios.
  initial begin
    checks = 0; fails = 0;
    reset = 1'b1;
    preloadEn = 1'b0; preloadAddr = '0; preloadData = 32'h0;
    a_req = 1'b0; a_addr = '0; a_wren = 1'b0; a_byteena = 4'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_addr = '0; b_wren = 1'b0; b_byteena = 4'h0; b_wdata = 32'h0;
    fork
      monitor();
    join_none
    @(posedge clock); #1;
    test_reset();
    preload(ADDR_W'(12'h010), 32'hDEADBEEF);
    preload(ADDR_W'(12'h020), 32'hAAAAAAAA);
    preload(ADDR_W'(12'h030), 32'hA0A0A030);
    preload(ADDR_W'(12'h031), 32'hB0B0B031);
    preload(ADDR_W'(12'h040), 32'h55667788);
    for (int i = 0; i < 8; i++) begin
      preload(ADDR_W'(12'h050 + i), 32'h10000000 + 32'h01010101 * i);
    end
    test_arbitration();
    test_single_read();
    test_byte_write();
    test_alternating();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
